// File: rtl/leaf_arb_pkg.sv
// leaf_arb_pkg: shared arbiter state type, stats width and round-robin search helper (rev 1.0).
`default_nettype none

package leaf_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int STAT_W = 32;
  localparam int RR_MAX = 16;

  // First set bit of vld[n-1:0] searching upward from ptr with wrap-around; 0 when none set.
  function automatic logic [3:0] rr_pick(input logic [RR_MAX-1:0] vld,
                                         input logic [3:0]        ptr,
                                         input int                n);
    logic [3:0] idx;
    int         j;
    idx = 4'd0;
    for (int k = RR_MAX - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (vld[j]) idx = 4'(j);
      end
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/leaf_rr_picker.sv
// leaf_rr_picker: combinational round-robin search from a pointer, up to 16 requesters (rev 1.0).
`default_nettype none

module leaf_rr_picker
  import leaf_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vld,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [RR_MAX-1:0] vld_ext;
  logic [3:0]        pick;

  always_comb begin
    vld_ext        = '0;
    vld_ext[N-1:0] = vld;
    pick           = rr_pick(vld_ext, 4'(ptr), N);
    idx            = SEL_W'(pick);
    found          = |vld;
  end

endmodule

`default_nettype wire

// File: rtl/leaf_stream_arbiter.sv
// leaf_stream_arbiter: round-robin, burst-holding share of one leaf output stream (rev 1.0).
// Define LEAF_STREAM_ARBITER_STATS_EN to add per-requester word counters and a stat_sel/stat_cnt read port.
`default_nettype none

module leaf_stream_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int SEL_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk_user,
  input  logic                      reset,
  input  logic [NUM_REQ*DATA_W-1:0] req_din,
  input  logic [NUM_REQ-1:0]        req_vld,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic [DATA_W-1:0]         out_dout,
  output logic [SEL_W-1:0]          out_src,
  output logic                      out_vld,
  input  logic                      out_ack,
  output logic                      busy
`ifdef LEAF_STREAM_ARBITER_STATS_EN
  ,
  input  logic [SEL_W-1:0]          stat_sel,
  output logic [STAT_W-1:0]         stat_cnt
`endif
);

  localparam int              CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  arb_state_e          state_q, state_d;
  logic [SEL_W-1:0]    grant_q, grant_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_vld_q, out_vld_d;
  logic [DATA_W-1:0]   out_dout_q, out_dout_d;
  logic [SEL_W-1:0]    out_src_q, out_src_d;

  logic [SEL_W-1:0]    pick_idx;
  logic                pick_found;
  logic                can_load;
  logic                accept;
  logic [SEL_W-1:0]    next_ptr;

  leaf_rr_picker #(
    .N     (NUM_REQ),
    .SEL_W (SEL_W)
  ) u_picker (
    .vld   (req_vld),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign can_load = ~out_vld_q | out_ack;
  assign next_ptr = (int'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + SEL_W'(1);

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    out_vld_d  = out_vld_q;
    out_dout_d = out_dout_q;
    out_src_d  = out_src_q;
    req_ack    = '0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (out_ack) out_vld_d = 1'b0;
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        accept           = req_vld[grant_q] & can_load;
        req_ack[grant_q] = accept;
        if (accept) begin
          out_dout_d = req_din[int'(grant_q)*DATA_W +: DATA_W];
          out_src_d  = grant_q;
          out_vld_d  = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
        end else if (out_ack) begin
          out_vld_d = 1'b0;
        end
        // Back-pressure alone keeps the grant; only a full burst or a source gap releases it.
        if ((accept && (cnt_q == CNT_LAST)) || (can_load && !req_vld[grant_q])) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_dout_q <= '0;
      out_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      out_vld_q  <= out_vld_d;
      out_dout_q <= out_dout_d;
      out_src_q  <= out_src_d;
    end
  end

  assign out_dout = out_dout_q;
  assign out_src  = out_src_q;
  assign out_vld  = out_vld_q;
  assign busy     = (state_q == GRANT);

`ifdef LEAF_STREAM_ARBITER_STATS_EN
  logic [STAT_W-1:0] word_cnt_q [NUM_REQ];
  logic [STAT_W-1:0] word_cnt_d [NUM_REQ];
  logic [STAT_W-1:0] stat_cnt_q, stat_cnt_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      word_cnt_d[i] = word_cnt_q[i] + STAT_W'(req_ack[i] & req_vld[i]);
    end
    stat_cnt_d = (int'(stat_sel) < NUM_REQ) ? word_cnt_q[stat_sel] : '0;
  end

  always_ff @(posedge clk_user or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) word_cnt_q[i] <= '0;
      stat_cnt_q <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_cnt = stat_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_leaf_stream_arbiter.sv
// tb_leaf_stream_arbiter: directed and randomized checks against a behavioural arbiter model.
`default_nettype none
`timescale 1ns/1ps

module tb_leaf_stream_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int BL  = 4;
  localparam int SW  = 2;
  localparam int BIG = 1 << 30;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] req_din;
  logic [N-1:0]  req_vld;
  logic [N-1:0]  req_ack;
  logic [DW-1:0] out_dout;
  logic [SW-1:0] out_src;
  logic          out_vld;
  logic          out_ack;
  logic          busy;
  logic [SW-1:0] stat_sel;
  logic [31:0]   stat_cnt;

  always #5 clk = ~clk;

  leaf_stream_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .BURST_LEN (BL)
  ) dut (
    .clk_user (clk),
    .reset    (rst),
    .req_din  (req_din),
    .req_vld  (req_vld),
    .req_ack  (req_ack),
    .out_dout (out_dout),
    .out_src  (out_src),
    .out_vld  (out_vld),
    .out_ack  (out_ack),
    .busy     (busy)
`ifdef LEAF_STREAM_ARBITER_STATS_EN
    ,
    .stat_sel (stat_sel),
    .stat_cnt (stat_cnt)
`endif
  );

`ifndef LEAF_STREAM_ARBITER_STATS_EN
  assign stat_cnt = 32'd0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Source model: each requester streams base+seq, seq advancing on each accepted word.
  logic [N-1:0] want;
  bit           rnd_mode;
  int           limit [N];
  int           seq   [N];
  logic [31:0]  base  [N];
  logic [N-1:0] acked;

  logic          obs_vld, obs_oack;
  logic [DW-1:0] obs_dout;
  logic [SW-1:0] obs_src;
  logic [N-1:0]  obs_ack;
  logic [31:0]   obs_stat;

  task automatic drive_now();
    logic v;
    for (int i = 0; i < N; i++) begin
      if (want[i]) v = (seq[i] < limit[i]);
      else if (rnd_mode) begin
        if (req_vld[i] && !acked[i]) v = ($urandom_range(7) != 0);
        else v = ($urandom_range(1) == 1);
      end else v = 1'b0;
      req_vld[i] = v;
      req_din[i*DW +: DW] = base[i] + 32'(seq[i]);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    obs_vld  = out_vld;
    obs_dout = out_dout;
    obs_src  = out_src;
    obs_ack  = req_ack;
    obs_oack = out_ack;
    obs_stat = stat_cnt;
    acked    = req_ack & req_vld;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acked[i]) seq[i]++;
    if (rnd_mode) begin
      out_ack  = ($urandom_range(3) != 0);
      stat_sel = SW'($urandom_range(N - 1));
    end
    drive_now();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    want     = '0;
    rnd_mode = 1'b0;
    acked    = '0;
    req_vld  = '0;
    for (int i = 0; i < N; i++) begin
      seq[i]   = 0;
      limit[i] = BIG;
      base[i]  = 32'(i) << 24;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_now();
  endtask

  // Behavioural reference: owner (-1 = idle), words sent in current burst, round-robin pointer, one output slot.
  int          m_owner, m_ptr, m_cnt, m_src;
  bit          m_ovld;
  logic [31:0] m_dout;
  int          m_cnts [N];
  logic [31:0] m_stat;
  int          delivered [N];

  always @(negedge clk) begin
    logic [N-1:0] exp_ack;
    bit           can;
    int           s;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_src = 0; m_ovld = 0; m_dout = '0; m_stat = '0;
      for (int i = 0; i < N; i++) begin m_cnts[i] = 0; delivered[i] = 0; end
    end else begin
      can     = !m_ovld || out_ack;
      exp_ack = '0;
      if (m_owner >= 0 && req_vld[m_owner] && can) exp_ack[m_owner] = 1'b1;
      check("req_ack", 32'(req_ack), 32'(exp_ack));
      check("out_vld", 32'(out_vld), 32'(m_ovld));
      check("busy", 32'(busy), 32'(m_owner >= 0));
      if (m_ovld) begin
        check("out_dout", out_dout, m_dout);
        check("out_src", 32'(out_src), 32'(m_src));
      end
`ifdef LEAF_STREAM_ARBITER_STATS_EN
      check("stat_cnt", stat_cnt, m_stat);
`endif
      if (out_vld && out_ack) begin
        s = int'(out_src);
        check("sb_order", out_dout, base[s] + 32'(delivered[s]));
        delivered[s]++;
      end
      m_stat = 32'(m_cnts[stat_sel]);
      for (int i = 0; i < N; i++) if (exp_ack[i]) m_cnts[i]++;
      if (m_owner < 0) begin
        if (out_ack) m_ovld = 0;
        if (req_vld != '0) begin
          for (int k = N - 1; k >= 0; k--)
            if (req_vld[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
          m_cnt = 0;
        end
      end else begin
        if (exp_ack[m_owner]) begin
          m_ovld = 1;
          m_dout = req_din[m_owner*DW +: DW];
          m_src  = m_owner;
          m_cnt++;
        end else if (out_ack) m_ovld = 0;
        if ((exp_ack[m_owner] && m_cnt == BL) || (can && !req_vld[m_owner])) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
    end
  end

  initial begin
    logic [31:0] held;
    logic [N-1:0] first_ack;
    int q [$];
    int run;
    logic [N-1:0] gap_exp [6];

    rst = 1'b1; out_ack = 1'b1; stat_sel = '0; req_vld = '0; req_din = '0;
    want = '0; rnd_mode = 1'b0; acked = '0;
    for (int i = 0; i < N; i++) begin seq[i] = 0; limit[i] = BIG; base[i] = 32'(i) << 24; end

    // Reset values
    @(negedge clk);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_dout", out_dout, 32'd0);
    check("rst_out_src", 32'(out_src), 32'd0);
    check("rst_stat_cnt", stat_cnt, 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Single requester, three words from source 2
    base[2] = 32'hA0; want = 4'b0100; limit[2] = 3; drive_now();
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("s1_vld", 32'(obs_vld), 32'(k >= 2 && k <= 4));
      if (k >= 2 && k <= 4) begin
        check("s1_dout", obs_dout, 32'hA0 + 32'(k - 2));
        check("s1_src", 32'(obs_src), 32'd2);
      end
      if (k == 1) check("s1_ack", 32'(obs_ack), 32'b0100);
    end
    // Pointer now 3: with 0,1,3 requesting, 3 wins
    want = 4'b1011; drive_now();
    cycle(); cycle();
    check("s1_rrptr", 32'(obs_ack), 32'b1000);
    want = '0; drive_now();
    repeat (8) cycle();

    // All four continuously requesting, 40 words
    do_reset();
    want = 4'b1111; out_ack = 1'b1; drive_now();
    for (int c = 0; c < 300 && q.size() < 40; c++) begin
      cycle();
      if (obs_vld && obs_oack) q.push_back(int'(obs_src));
    end
    want = '0; drive_now();
    check("s2_words", 32'(q.size()), 32'd40);
    for (int k = 0; k < q.size(); k++) check("s2_src_seq", 32'(q[k]), 32'((k / BL) % N));
    repeat (4) cycle();
`ifdef LEAF_STREAM_ARBITER_STATS_EN
    for (int s = 0; s < N; s++) begin
      stat_sel = SW'(s);
      cycle(); cycle();
      check("s2_stat", obs_stat, 32'd10);
    end
`endif

    // Back-pressure for 5 cycles in the middle of source 0's burst
    do_reset();
    want = 4'b1111; drive_now();
    q.delete();
    for (int c = 0; c < 30; c++) begin
      out_ack = !(c >= 4 && c < 9);
      cycle();
      if (c == 4) held = obs_dout;
      if (c >= 4 && c < 9) begin
        check("s3_ack_low", 32'(obs_ack), 32'd0);
        check("s3_dout_hold", obs_dout, held);
      end
      if (obs_vld && obs_oack) q.push_back(int'(obs_src));
    end
    out_ack = 1'b1; want = '0; drive_now();
    run = 0;
    while (run < q.size() && q[run] == 0) run++;
    check("s3_burst_len", 32'(run), 32'(BL));
    repeat (6) cycle();

    // Source 1 gaps after two words; pending source 3 follows
    do_reset();
    want = 4'b1010; limit[1] = 2; drive_now();
    gap_exp[0] = 4'b0000; gap_exp[1] = 4'b0010; gap_exp[2] = 4'b0010;
    gap_exp[3] = 4'b0000; gap_exp[4] = 4'b0000; gap_exp[5] = 4'b1000;
    for (int c = 0; c < 6; c++) begin
      cycle();
      check("s4_gap_ack", 32'(obs_ack), 32'(gap_exp[c]));
    end
    want = '0; drive_now();
    repeat (8) cycle();

    // Asynchronous reset between edges in the middle of a burst
    do_reset();
    want = 4'b1111; drive_now();
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    check("s5_async_vld", 32'(out_vld), 32'd0);
    check("s5_async_ack", 32'(req_ack), 32'd0);
    check("s5_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    drive_now();
    first_ack = '0;
    for (int c = 0; c < 4; c++) begin
      cycle();
      if (first_ack == '0) first_ack = obs_ack;
    end
    check("s5_first_grant", 32'(first_ack), 32'b0001);
    want = '0; drive_now();
    repeat (8) cycle();

    // Randomized traffic and back-pressure
    do_reset();
    rnd_mode = 1'b1; drive_now();
    repeat (3000) cycle();
    rnd_mode = 1'b0; out_ack = 1'b1; drive_now();
    repeat (10) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
